// File: rtl/fpu_addsub_pipe_pkg.sv
// Shared types, status bit positions and format helpers for the floating-point add/subtract unit.
package fpu_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_UNPACK,
    S_ALIGN,
    S_ADD,
    S_NORM,
    S_ROUND,
    S_DONE
  } state_t;

  localparam int unsigned ST_EXACT = 3;
  localparam int unsigned ST_OVF   = 2;
  localparam int unsigned ST_UNF   = 1;
  localparam int unsigned ST_INEX  = 0;

  function automatic int unsigned bias(input int unsigned exp_w);
    return (32'd1 << (exp_w - 1)) - 32'd1;
  endfunction

  // Quiet NaN: all-ones exponent plus the fraction MSB, positive sign.
  function automatic logic [63:0] canonical_nan(input int unsigned exp_w, input int unsigned man_w);
    logic [63:0] ones;
    ones = (64'd1 << (exp_w + 1)) - 64'd1;
    return ones << (man_w - 1);
  endfunction

endpackage

// File: rtl/fpu_addsub_pipe_if.sv
// Operand/result handshake bundle between the issuing stage and the add/subtract unit.
interface fpu_addsub_pipe_if #(
  parameter int unsigned W = 32
);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         op_sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] data_out;
  logic [3:0]   status_out;
  logic         busy;

  modport master (
    output in_valid, op_a, op_b, op_sub, out_ready,
    input  in_ready, out_valid, data_out, status_out, busy
  );

  modport slave (
    input  in_valid, op_a, op_b, op_sub, out_ready,
    output in_ready, out_valid, data_out, status_out, busy
  );
endinterface

// File: rtl/fpu_addsub_pipe_lzc.sv
// Combinational leading-zero counter; an all-zero input reports WIDTH.
module fpu_lzc #(
  parameter int unsigned WIDTH = 24
) (
  input  logic [WIDTH-1:0]         in_i,
  output logic [$clog2(WIDTH+1)-1:0] cnt_o
);
  localparam int unsigned CW = $clog2(WIDTH + 1);

  logic found;

  always_comb begin
    cnt_o = CW'(WIDTH);
    found = 1'b0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (!found && in_i[WIDTH-1-i]) begin
        cnt_o = CW'(i);
        found = 1'b1;
      end
    end
  end
endmodule

// File: rtl/fpu_addsub_pipe.sv
// Multi-cycle floating-point add/subtract with RNE rounding, DAZ/FTZ and a single operation in flight.
module fpu_addsub_pipe
  import fpu_pkg::*;
#(
  parameter int unsigned EXP_W = 11,
  parameter int unsigned MAN_W = 20
) (
  input  logic               clock_100k,
  input  logic               reset,
  fpu_addsub_pipe_if.slave   bus
);
  localparam int unsigned W  = 1 + EXP_W + MAN_W;
  localparam int unsigned MW = MAN_W + 1;
  localparam int unsigned DW = MAN_W + 4;
  localparam int unsigned EW = EXP_W + 2;
  localparam int unsigned LW = $clog2(DW + 1);

  localparam logic [EXP_W-1:0]       EXP_MAX    = '1;
  localparam logic [EXP_W-1:0]       D_COLLAPSE = EXP_W'(DW - 1);
  localparam logic signed [EW-1:0]   ONE        = $signed({{(EW-1){1'b0}}, 1'b1});
  localparam logic signed [EW-1:0]   EXP_TOP    = $signed({2'b00, {EXP_W{1'b1}}});
  localparam logic [W-1:0]           QNAN       = W'(canonical_nan(EXP_W, MAN_W));

  state_t state_q, state_d;

  logic [W-1:0]             a_q, b_q;
  logic                     sa_q, sb_q;
  logic [EXP_W-1:0]         ea_q, eb_q;
  logic [MW-1:0]            ma_q, mb_q;
  logic                     sign_q, sub_q, zero_q, unf_q;
  logic signed [EW-1:0]     exp_q;
  logic [DW-1:0]            mx_q, my_q, nm_q;
  logic [DW:0]              sum_q;
  logic [W-1:0]             res_q, data_out_q;
  logic [3:0]               res_st_q, status_q;
  logic                     out_valid_q;

  // Unpack: classify operands, flush subnormals, resolve specials
  logic [EXP_W-1:0] ea_u, eb_u;
  logic [MAN_W-1:0] fa_u, fb_u;
  logic             a_inf, b_inf, a_nan, b_nan, special_d;
  logic [W-1:0]     special_res_d;

  always_comb begin
    ea_u  = a_q[W-2:MAN_W];
    eb_u  = b_q[W-2:MAN_W];
    fa_u  = a_q[MAN_W-1:0];
    fb_u  = b_q[MAN_W-1:0];
    a_inf = (ea_u == EXP_MAX) && (fa_u == '0);
    b_inf = (eb_u == EXP_MAX) && (fb_u == '0);
    a_nan = (ea_u == EXP_MAX) && (fa_u != '0);
    b_nan = (eb_u == EXP_MAX) && (fb_u != '0);
    special_d     = 1'b1;
    special_res_d = '0;
    if (a_nan || b_nan || (a_inf && b_inf && (a_q[W-1] != b_q[W-1]))) begin
      special_res_d = QNAN;
    end else if (a_inf) begin
      special_res_d = {a_q[W-1], EXP_MAX, {MAN_W{1'b0}}};
    end else if (b_inf) begin
      special_res_d = {b_q[W-1], EXP_MAX, {MAN_W{1'b0}}};
    end else begin
      special_d = 1'b0;
    end
  end

  // Align: larger magnitude goes to x, smaller is shifted right with sticky collection
  logic             swap_a, sign_a;
  logic [EXP_W-1:0] ex_a, ey_a, d_a;
  logic [MW-1:0]    mx_a, my_a;
  logic [DW-1:0]    my_full, my_al;

  always_comb begin
    swap_a  = {eb_q, mb_q} > {ea_q, ma_q};
    ex_a    = swap_a ? eb_q : ea_q;
    ey_a    = swap_a ? ea_q : eb_q;
    mx_a    = swap_a ? mb_q : ma_q;
    my_a    = swap_a ? ma_q : mb_q;
    sign_a  = swap_a ? sb_q : sa_q;
    d_a     = ex_a - ey_a;
    my_full = {my_a, 3'b000};
    if (d_a >= D_COLLAPSE) begin
      my_al = {{(DW-1){1'b0}}, |my_a};
    end else begin
      my_al = (my_full >> d_a)
            | {{(DW-1){1'b0}}, |(my_full & ~({DW{1'b1}} << d_a))};
    end
  end

  logic [DW:0] sum_d;
  logic        zero_d;

  always_comb begin
    sum_d  = sub_q ? ({1'b0, mx_q} - {1'b0, my_q}) : ({1'b0, mx_q} + {1'b0, my_q});
    zero_d = (sum_d == '0);
  end

  // Normalize: carry shifts right with sticky fold, otherwise left by leading-zero count
  logic [LW-1:0]        lz;
  logic [DW-1:0]        nm_d;
  logic signed [EW-1:0] exp_n;
  logic                 unf_d;

  fpu_lzc #(.WIDTH(DW)) u_lzc (
    .in_i  (sum_q[DW-1:0]),
    .cnt_o (lz)
  );

  always_comb begin
    if (sum_q[DW]) begin
      nm_d  = {sum_q[DW:2], |sum_q[1:0]};
      exp_n = exp_q + ONE;
    end else begin
      nm_d  = sum_q[DW-1:0] << lz;
      exp_n = exp_q - $signed({{(EW-LW){1'b0}}, lz});
    end
    unf_d = !zero_q && (exp_n < ONE);
  end

  // Round to nearest even, then classify the final result
  logic                 g_r, r_r, s_r, inc_r, inex_r;
  logic [MW:0]          mr;
  logic [MAN_W-1:0]     frac_r;
  logic signed [EW-1:0] exp_r;
  logic [W-1:0]         round_res;
  logic [3:0]           round_st;

  always_comb begin
    g_r    = nm_q[2];
    r_r    = nm_q[1];
    s_r    = nm_q[0];
    inex_r = g_r | r_r | s_r;
    inc_r  = g_r & (r_r | s_r | nm_q[3]);
    mr     = {1'b0, nm_q[DW-1:3]} + {{MW{1'b0}}, inc_r};
    frac_r = mr[MW] ? mr[MW-1:1] : mr[MAN_W-1:0];
    exp_r  = mr[MW] ? (exp_q + ONE) : exp_q;
    round_st = '0;
    if (zero_q) begin
      round_res          = {sign_q, {(W-1){1'b0}}};
      round_st[ST_EXACT] = 1'b1;
    end else if (unf_q) begin
      round_res          = {sign_q, {(W-1){1'b0}}};
      round_st[ST_UNF]   = 1'b1;
      round_st[ST_INEX]  = 1'b1;
    end else if (exp_r >= EXP_TOP) begin
      round_res          = {sign_q, EXP_MAX, {MAN_W{1'b0}}};
      round_st[ST_OVF]   = 1'b1;
      round_st[ST_INEX]  = 1'b1;
    end else begin
      round_res          = {sign_q, exp_r[EXP_W-1:0], frac_r};
      round_st[ST_INEX]  = inex_r;
      round_st[ST_EXACT] = !inex_r;
    end
  end

  always_ff @(posedge clock_100k or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (bus.in_valid) state_d = S_UNPACK;
      S_UNPACK: state_d = special_d ? S_DONE : S_ALIGN;
      S_ALIGN:  state_d = S_ADD;
      S_ADD:    state_d = S_NORM;
      S_NORM:   state_d = S_ROUND;
      S_ROUND:  state_d = S_DONE;
      S_DONE:   if (out_valid_q && bus.out_ready) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready   = (state_q == S_IDLE);
    bus.busy       = (state_q != S_IDLE);
    bus.out_valid  = out_valid_q;
    bus.data_out   = data_out_q;
    bus.status_out = status_q;
  end

  always_ff @(posedge clock_100k or posedge reset) begin
    if (reset) begin
      a_q <= '0; b_q <= '0;
      sa_q <= 1'b0; sb_q <= 1'b0; ea_q <= '0; eb_q <= '0; ma_q <= '0; mb_q <= '0;
      sign_q <= 1'b0; sub_q <= 1'b0; zero_q <= 1'b0; unf_q <= 1'b0;
      exp_q <= '0; mx_q <= '0; my_q <= '0; nm_q <= '0; sum_q <= '0;
      res_q <= '0; res_st_q <= '0;
      data_out_q <= '0; status_q <= '0; out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.in_valid) begin
            a_q <= bus.op_a;
            b_q <= {bus.op_b[W-1] ^ bus.op_sub, bus.op_b[W-2:0]};
          end
        end
        S_UNPACK: begin
          sa_q <= a_q[W-1];
          sb_q <= b_q[W-1];
          ea_q <= ea_u;
          eb_q <= eb_u;
          ma_q <= (ea_u == '0) ? '0 : {1'b1, fa_u};
          mb_q <= (eb_u == '0) ? '0 : {1'b1, fb_u};
          if (special_d) begin
            res_q    <= special_res_d;
            res_st_q <= '0;
          end
        end
        S_ALIGN: begin
          sign_q <= sign_a;
          sub_q  <= sa_q ^ sb_q;
          exp_q  <= $signed({2'b00, ex_a});
          mx_q   <= {mx_a, 3'b000};
          my_q   <= my_al;
        end
        S_ADD: begin
          sum_q  <= sum_d;
          zero_q <= zero_d;
          if (zero_d && sub_q) sign_q <= 1'b0;
        end
        S_NORM: begin
          nm_q  <= nm_d;
          exp_q <= exp_n;
          unf_q <= unf_d;
        end
        S_ROUND: begin
          res_q    <= round_res;
          res_st_q <= round_st;
        end
        // First DONE cycle publishes the result; out_valid rises one edge later.
        S_DONE: begin
          if (!out_valid_q) begin
            data_out_q  <= res_q;
            status_q    <= res_st_q;
            out_valid_q <= 1'b1;
          end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_fpu_addsub_pipe.sv
// Directed and randomized checks of fpu_addsub_pipe against an exact-arithmetic reference.
module tb_fpu_addsub_pipe;
  import fpu_pkg::*;

  localparam int EXPW  = 11;
  localparam int MANW  = 20;
  localparam int EMAXV = 2047;
  localparam int NRAND = 4000;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  fpu_addsub_pipe_if #(.W(32)) bus ();

  fpu_addsub_pipe #(.EXP_W(EXPW), .MAN_W(MANW)) dut (
    .clock_100k (clk),
    .reset      (rst),
    .bus        (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Exact value of the sum as an integer mantissa on a common scale, then rounded once.
  function automatic void ref_model(input logic [31:0] a, input logic [31:0] b_in, input logic sub,
                                    output logic [31:0] r, output logic [3:0] st);
    logic [31:0] b;
    int ea, eb, eg, es, d, dd, base, p, en, sh;
    logic sa, sb, sg, ss, sign, up;
    longint unsigned ma, mb, mg, ms, m, mant, rem, half;
    b     = b_in;
    b[31] = b_in[31] ^ sub;
    sa = a[31]; sb = b[31];
    ea = int'(a[30:20]); eb = int'(b[30:20]);
    if ((ea == EMAXV && a[19:0] != 0) || (eb == EMAXV && b[19:0] != 0) ||
        (ea == EMAXV && eb == EMAXV && sa != sb)) begin
      r = 32'h7FF80000; st = 4'b0000; return;
    end
    if (ea == EMAXV) begin r = {sa, 11'h7FF, 20'h0}; st = 4'b0000; return; end
    if (eb == EMAXV) begin r = {sb, 11'h7FF, 20'h0}; st = 4'b0000; return; end
    ma = (ea == 0) ? 64'd0 : {43'd0, 1'b1, a[19:0]};
    mb = (eb == 0) ? 64'd0 : {43'd0, 1'b1, b[19:0]};
    if (ea > eb || (ea == eb && ma >= mb)) begin
      eg = ea; mg = ma; sg = sa; es = eb; ms = mb; ss = sb;
    end else begin
      eg = eb; mg = mb; sg = sb; es = ea; ms = ma; ss = sa;
    end
    d    = eg - es;
    dd   = (d > 42) ? 42 : d;
    base = eg - dd;
    mg   = mg << dd;
    m    = (sg == ss) ? (mg + ms) : (mg - ms);
    sign = sg;
    if (m == 0) begin
      r = {(sa == sb) ? sa : 1'b0, 31'd0}; st = 4'b1000; return;
    end
    p = 63;
    while (!m[p]) p--;
    en = base + p - MANW;
    if (en < 1) begin r = {sign, 31'd0}; st = 4'b0011; return; end
    rem = 0;
    if (p > MANW) begin
      sh   = p - MANW;
      mant = m >> sh;
      rem  = m & ((64'd1 << sh) - 64'd1);
      half = 64'd1 << (sh - 1);
      up   = (rem > half) || (rem == half && mant[0]);
      mant = mant + {63'd0, up};
      if (mant == (64'd1 << (MANW + 1))) begin
        mant = mant >> 1;
        en++;
      end
    end else begin
      mant = m << (MANW - p);
    end
    if (en >= EMAXV) begin
      r = {sign, 11'h7FF, 20'h0}; st = 4'b0101;
    end else begin
      r  = {sign, en[10:0], mant[19:0]};
      st = (rem != 0) ? 4'b0001 : 4'b1000;
    end
  endfunction

  // Issue one op with out_ready high; returns result, status and edges from accept to out_valid.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic sub,
                        output logic [31:0] r, output logic [3:0] st, output int lat);
    @(negedge clk);
    bus.op_a = a; bus.op_b = b; bus.op_sub = sub; bus.in_valid = 1'b1;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    lat = 0;
    while (!bus.out_valid && lat < 40) begin
      @(posedge clk);
      #1 lat++;
    end
    check("out_valid_seen", {31'd0, bus.out_valid}, 32'd1);
    r  = bus.data_out;
    st = bus.status_out;
    @(posedge clk);
    #1;
  endtask

  logic [31:0] a, b, r, er;
  logic [3:0]  st, est;
  logic        sub;
  int          lat, k, e;

  initial begin
    checks = 0; failures = 0;
    rst = 1'b0;
    bus.in_valid = 1'b0; bus.op_a = '0; bus.op_b = '0; bus.op_sub = 1'b0; bus.out_ready = 1'b1;
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst in_ready", {31'd0, bus.in_ready}, 32'd1);
    check("rst out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("rst data_out", bus.data_out, 32'd0);
    check("rst status", {28'd0, bus.status_out}, 32'd0);
    check("rst busy", {31'd0, bus.busy}, 32'd0);
    @(negedge clk) rst = 1'b0;

    run_op(32'h3FF00000, 32'h40000000, 1'b0, r, st, lat);
    check("1+2 data", r, 32'h40080000);
    check("1+2 status", {28'd0, st}, 32'h8);
    check("1+2 latency", lat, 32'd6);

    run_op(32'h3FF00000, 32'h3FF00000, 1'b1, r, st, lat);
    check("1-1 data", r, 32'h00000000);
    check("1-1 status", {28'd0, st}, 32'h8);

    run_op(32'h3FF00000, 32'h3EA00000, 1'b0, r, st, lat);
    check("tie even data", r, 32'h3FF00000);
    check("tie even status", {28'd0, st}, 32'h1);
    run_op(32'h3FF00001, 32'h3EA00000, 1'b0, r, st, lat);
    check("tie odd data", r, 32'h3FF00002);
    check("tie odd status", {28'd0, st}, 32'h1);

    run_op(32'h7FEFFFFF, 32'h7FEFFFFF, 1'b0, r, st, lat);
    check("ovf data", r, 32'h7FF00000);
    check("ovf status", {28'd0, st}, 32'h5);
    run_op(32'h7FF00000, 32'h7FF00000, 1'b1, r, st, lat);
    check("inf-inf data", r, 32'h7FF80000);
    check("inf-inf status", {28'd0, st}, 32'h0);

    run_op(32'h00180000, 32'h00100000, 1'b1, r, st, lat);
    check("unf data", r, 32'h00000000);
    check("unf status", {28'd0, st}, 32'h3);
    run_op(32'h00000001, 32'h3FF00000, 1'b0, r, st, lat);
    check("daz data", r, 32'h3FF00000);
    check("daz status", {28'd0, st}, 32'h8);

    bus.out_ready = 1'b0;
    @(negedge clk);
    bus.op_a = 32'h40000000; bus.op_b = 32'h40000000; bus.op_sub = 1'b0; bus.in_valid = 1'b1;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    lat = 0;
    while (!bus.out_valid && lat < 40) begin
      @(posedge clk);
      #1 lat++;
    end
    check("hold valid", {31'd0, bus.out_valid}, 32'd1);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      check("hold data", bus.data_out, 32'h40100000);
      check("hold status", {28'd0, bus.status_out}, 32'h8);
      check("hold in_ready", {31'd0, bus.in_ready}, 32'd0);
      check("hold out_valid", {31'd0, bus.out_valid}, 32'd1);
    end
    @(negedge clk) bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("release out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("release in_ready", {31'd0, bus.in_ready}, 32'd1);

    @(negedge clk);
    bus.op_a = 32'h3FF00000; bus.op_b = 32'h40000000; bus.op_sub = 1'b0; bus.in_valid = 1'b1;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("abort data_out", bus.data_out, 32'd0);
    check("abort status", {28'd0, bus.status_out}, 32'd0);
    check("abort out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("abort in_ready", {31'd0, bus.in_ready}, 32'd1);
    check("abort busy", {31'd0, bus.busy}, 32'd0);
    @(negedge clk) rst = 1'b0;
    run_op(32'h40000000, 32'h3FF00000, 1'b1, r, st, lat);
    check("post-abort data", r, 32'h3FF00000);
    check("post-abort status", {28'd0, st}, 32'h8);

    for (int n = 0; n < NRAND; n++) begin
      a = $urandom; b = $urandom; sub = 1'($urandom_range(0, 1));
      k = int'($urandom_range(0, 15));
      if (k < 10) begin
        e = int'(a[30:20]) + int'($urandom_range(0, 48)) - 24;
        if (e < 0) e = 0;
        if (e > EMAXV) e = EMAXV;
        b[30:20] = e[10:0];
      end else if (k == 10) begin
        b = a;
      end else if (k == 11) begin
        a[30:20] = '1;
        if ($urandom_range(0, 1) == 1) a[19:0] = '0;
      end else if (k == 12) begin
        b[30:20] = '0;
      end else if (k == 13) begin
        a[30:20] = 11'($urandom_range(1, 3));
        b[30:20] = 11'($urandom_range(1, 3));
      end else if (k == 14) begin
        a[30:20] = 11'($urandom_range(2040, 2046));
        b[30:20] = 11'($urandom_range(2040, 2046));
      end
      ref_model(a, b, sub, er, est);
      run_op(a, b, sub, r, st, lat);
      check($sformatf("rand%0d %h%s%h data", n, a, sub ? "-" : "+", b), r, er);
      check($sformatf("rand%0d status", n), {28'd0, st}, {28'd0, est});
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
